// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchroniser plus counter-based stability filter for a raw async input
//
// Purpose:
//   Turns a raw, asynchronous single-bit input into a clean level in the clk
//   domain. An N-flop synchroniser feeds a two-state filter. db_out follows
//   the synchronised input only after that input has differed from db_out for
//   STABLE_CYCLES consecutive enabled edges.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   filter enable; low freezes db_out and clears qualification
//   raw_in     in   unsynchronised raw input
//   db_out     out  debounced level (registered)
//   busy       out  high while a candidate transition is being qualified
//   glitch_cnt out  16-bit saturating count of rejected glitches
//
// Build option:
//   DEBOUNCE_GLITCH_CNT_EN - when defined, glitch_cnt counts CHECK->STABLE
//   reverts; when undefined, glitch_cnt is tied to zero.

module input_debouncer #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned CNT_W         = 8,
   parameter logic        RESET_LEVEL   = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        raw_in,
   output logic        db_out,
   output logic        busy,
   output logic [15:0] glitch_cnt
);

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_CHECK  = 1'b1
   } state_t;

   // Counter value at which the last qualifying edge is being taken.
   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_sync_out;
   logic                   w_diff;
   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_db;
   logic                   r_busy;

   // Synchroniser runs independently of en.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
      end
   end

   assign w_sync_out = r_sync[SYNC_STAGES-1];
   assign w_diff     = (w_sync_out != r_db);

   // Stability filter. busy is registered alongside the state so that it is
   // a pure flop output with no combinational path from raw_in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_STABLE;
         r_cnt   <= '0;
         r_db    <= RESET_LEVEL;
         r_busy  <= 1'b0;
      end else if (!en) begin
         r_state <= ST_STABLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_STABLE: begin
               if (w_diff) begin
                  if (STABLE_CYCLES == 1) begin
                     // A single differing edge is already enough.
                     r_db  <= w_sync_out;
                     r_cnt <= '0;
                  end else begin
                     r_state <= ST_CHECK;
                     r_cnt   <= LP_CNT_ONE;
                     r_busy  <= 1'b1;
                  end
               end else begin
                  r_cnt <= '0;
               end
            end
            ST_CHECK: begin
               if (!w_diff) begin
                  // Input reverted before qualifying: reject as glitch.
                  r_state <= ST_STABLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else if (r_cnt == LP_CNT_LAST) begin
                  r_db    <= w_sync_out;
                  r_state <= ST_STABLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + LP_CNT_ONE;
               end
            end
            default: begin
               r_state <= ST_STABLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign db_out = r_db;
   assign busy   = r_busy;

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic        w_glitch;
   logic [15:0] r_glitch_cnt;

   // Only a revert while qualifying counts; en=0 aborts and successful
   // qualifications do not.
   assign w_glitch = en && (r_state == ST_CHECK) && !w_diff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_glitch_cnt <= 16'h0000;
      end else if (w_glitch && (r_glitch_cnt != 16'hFFFF)) begin
         r_glitch_cnt <= r_glitch_cnt + 16'h0001;
      end
   end

   assign glitch_cnt = r_glitch_cnt;
`else
   assign glitch_cnt = 16'h0000;
`endif

endmodule
